// File: rtl/layer_ram_pkg.sv
// Shared types and constants for the layer-RAM arbiter.
// State encoding, DQM lane masks and the channel-index width helper.
package layer_ram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    localparam logic [1:0] DQM_NONE = 2'b00;
    localparam logic [1:0] DQM_LO   = 2'b01;
    localparam logic [1:0] DQM_HI   = 2'b10;

    function automatic int CH_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_ram_arbiter_if.sv
// Requestor and SDRAM-controller host bus seen by the layer-RAM arbiter.
// master = arbiter side, slave = requestors plus controller.
interface layer_ram_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 25
) ();
    import layer_ram_pkg::*;

    localparam int CW = CH_W(NUM_CH);

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH-1:0]        ch_byte;
    logic [NUM_CH*ADDR_W-1:0] ch_addr_bytes;
    logic [NUM_CH*16-1:0]     ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;

    logic                     rd_valid;
    logic [CW-1:0]            rd_ch;
    logic [15:0]              rd_data;
    logic                     rd_err;
    logic                     busy;

    logic [ADDR_W-2:0]        mem_wr_addr;
    logic [15:0]              mem_wr_data;
    logic                     mem_wr_en;
    logic [1:0]               mem_wr_dqm;
    logic [ADDR_W-2:0]        mem_rd_addr;
    logic                     mem_rd_en;
    logic [15:0]              mem_rd_data;
    logic                     mem_rd_ready;
    logic                     mem_busy;

    modport master (
        input  ch_req, ch_we, ch_byte, ch_addr_bytes, ch_wdata,
        input  mem_rd_data, mem_rd_ready, mem_busy,
        output ch_gnt, rd_valid, rd_ch, rd_data, rd_err, busy,
        output mem_wr_addr, mem_wr_data, mem_wr_en, mem_wr_dqm,
        output mem_rd_addr, mem_rd_en
    );

    modport slave (
        output ch_req, ch_we, ch_byte, ch_addr_bytes, ch_wdata,
        output mem_rd_data, mem_rd_ready, mem_busy,
        input  ch_gnt, rd_valid, rd_ch, rd_data, rd_err, busy,
        input  mem_wr_addr, mem_wr_data, mem_wr_en, mem_wr_dqm,
        input  mem_rd_addr, mem_rd_en
    );

endinterface

// File: rtl/layer_ram_pick.sv
// Combinational winner select: requests (+ pointer) to one-hot grant and index.
// LAYER_RAM_RR_EN: round-robin from ptr+1; otherwise lowest index wins.
module layer_ram_pick
    import layer_ram_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CW     = CH_W(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
`ifdef LAYER_RAM_RR_EN
    input  logic [CW-1:0]     ptr,
`endif
    output logic [NUM_CH-1:0] gnt,
    output logic [CW-1:0]     idx
);

    always_comb begin
        gnt = '0;
        idx = '0;
`ifdef LAYER_RAM_RR_EN
        // farthest first, so the nearest channel after ptr overrides
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_CH]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % NUM_CH] = 1'b1;
                idx = CW'((int'(ptr) + k) % NUM_CH);
            end
        end
`else
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt = '0;
                gnt[k] = 1'b1;
                idx = CW'(k);
            end
        end
`endif
    end

endmodule

// File: rtl/layer_ram_arbiter.sv
// N-channel front end to the layer-RAM SDRAM controller, one op at a time.
// Define LAYER_RAM_RR_EN for round-robin; default is fixed priority.
module layer_ram_arbiter
    import layer_ram_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 25,
    parameter int TIMEOUT_CYC = 64
) (
    input logic clk,
    input logic rst,
    layer_ram_arbiter_if.master bus
);

    localparam int CW = CH_W(NUM_CH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   pick_gnt;
    logic [CW-1:0]       pick_idx;
    logic                w_we;
    logic                w_byte;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_wdata;
    logic                sel_we;
    logic                sel_byte;
    logic [ADDR_W-1:0]   sel_addr;
    logic [15:0]         sel_wdata;
    logic [CW-1:0]       sel_ch;
    logic [TW-1:0]       cnt;
    logic                take;
    logic                do_wr;
    logic                do_rd;
    logic                resp_ok;
    logic                resp_to;
    logic [15:0]         rd_lane;
`ifdef LAYER_RAM_RR_EN
    logic [CW-1:0]       ptr;
`endif

    layer_ram_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick (
        .req (bus.ch_req),
`ifdef LAYER_RAM_RR_EN
        .ptr (ptr),
`endif
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        w_we    = 1'b0;
        w_byte  = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pick_gnt[c]) begin
                w_we    = bus.ch_we[c];
                w_byte  = bus.ch_byte[c];
                w_addr  = bus.ch_addr_bytes[c*ADDR_W +: ADDR_W];
                w_wdata = bus.ch_wdata[c*16 +: 16];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        resp_ok   = 1'b0;
        resp_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.ch_req && !bus.mem_busy) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                do_wr     = sel_we;
                do_rd     = !sel_we;
                state_nxt = sel_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.mem_rd_ready) begin
                    resp_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
                    resp_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        rd_lane = bus.mem_rd_data;
        if (sel_byte)
            rd_lane = sel_addr[0] ? {8'h00, bus.mem_rd_data[15:8]}
                                  : {8'h00, bus.mem_rd_data[7:0]};
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_we          <= 1'b0;
            sel_byte        <= 1'b0;
            sel_addr        <= '0;
            sel_wdata       <= '0;
            sel_ch          <= '0;
            cnt             <= '0;
            bus.ch_gnt      <= '0;
            bus.rd_valid    <= 1'b0;
            bus.rd_ch       <= '0;
            bus.rd_data     <= '0;
            bus.rd_err      <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_dqm  <= '0;
            bus.mem_rd_addr <= '0;
            bus.mem_rd_en   <= 1'b0;
        end else begin
            bus.ch_gnt    <= take ? pick_gnt : '0;
            bus.mem_wr_en <= do_wr;
            bus.mem_rd_en <= do_rd;
            bus.rd_valid  <= resp_ok | resp_to;
            bus.rd_err    <= resp_to;
            cnt <= (state == WAIT_RD) ? cnt + 1'b1 : '0;
            if (take) begin
                sel_we    <= w_we;
                sel_byte  <= w_byte;
                sel_addr  <= w_addr;
                sel_wdata <= w_wdata;
                sel_ch    <= pick_idx;
            end
            if (do_wr) begin
                bus.mem_wr_addr <= sel_addr[ADDR_W-1:1];
                bus.mem_wr_data <= sel_byte ? {2{sel_wdata[7:0]}} : sel_wdata;
                // mask the lane that is not being written
                bus.mem_wr_dqm  <= !sel_byte   ? DQM_NONE :
                                   sel_addr[0] ? DQM_LO : DQM_HI;
            end
            if (do_rd) bus.mem_rd_addr <= sel_addr[ADDR_W-1:1];
            if (resp_ok | resp_to) begin
                bus.rd_ch   <= sel_ch;
                bus.rd_data <= resp_ok ? rd_lane : '0;
            end
        end
    end

`ifdef LAYER_RAM_RR_EN
    always_ff @(posedge clk) begin
        if (!rst)      ptr <= '0;
        else if (take) ptr <= pick_idx;
    end
`endif

endmodule

// File: tb/tb_layer_ram_arbiter.sv
// Bench for layer_ram_arbiter: directed steps then randomized traffic
// checked against a transaction-level reference model.
module tb_layer_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int T  = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    layer_ram_arbiter_if #(.NUM_CH(N), .ADDR_W(AW)) bus ();

    layer_ram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic            f_we   [N];
    logic            f_bt   [N];
    logic [AW-1:0]   f_addr [N];
    logic [15:0]     f_wd   [N];
`ifdef LAYER_RAM_RR_EN
    int last = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int winner(input logic [N-1:0] m);
`ifdef LAYER_RAM_RR_EN
        for (int k = 1; k <= N; k++)
            if (m[(last + k) % N]) return (last + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (m[k]) return k;
`endif
        return 0;
    endfunction

    task automatic note_grant(input int w);
`ifdef LAYER_RAM_RR_EN
        last = w;
`else
        if (w < 0) $display("bad winner %0d", w);
`endif
    endtask

    task automatic model_reset;
`ifdef LAYER_RAM_RR_EN
        last = 0;
`endif
    endtask

    function automatic logic [15:0] exp_rdata(input logic bt,
            input logic [AW-1:0] a, input logic [15:0] d);
        if (!bt) return d;
        return (d >> (8 * a[0])) & 16'h00FF;
    endfunction

    function automatic logic [15:0] exp_wdata(input logic bt,
            input logic [15:0] w);
        return bt ? w[7:0] * 16'h0101 : w;
    endfunction

    function automatic logic [1:0] exp_dqm(input logic bt,
            input logic [AW-1:0] a);
        if (!bt) return 2'b00;
        return ~(2'b01 << a[0]) & 2'b11;
    endfunction

    task automatic set_ch(input int c, input logic we, input logic bt,
                          input logic [AW-1:0] a, input logic [15:0] w);
        bus.ch_we[c]                = we;
        bus.ch_byte[c]              = bt;
        bus.ch_addr_bytes[c*AW +: AW] = a;
        bus.ch_wdata[c*16 +: 16]    = w;
        f_we[c]   = we;
        f_bt[c]   = bt;
        f_addr[c] = a;
        f_wd[c]   = w;
    endtask

    task automatic new_req(input int c);
        set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom), 16'($urandom));
    endtask

    task automatic grant(input logic [N-1:0] pend, output int w);
        bus.ch_req = pend;
        w = winner(pend);
        tick;
        check("gnt", 32'(bus.ch_gnt), 32'(1) << w);
        note_grant(w);
    endtask

    // Called at the negedge of the gnt cycle; ends in the IDLE cycle after.
    task automatic serve(input int c, input int dly, input logic [15:0] rd);
        tick;
        if (f_we[c]) begin
            check("wr_en", 32'(bus.mem_wr_en), 1);
            check("wr_addr", 32'(bus.mem_wr_addr), 32'(f_addr[c] >> 1));
            check("wr_data", 32'(bus.mem_wr_data), 32'(exp_wdata(f_bt[c], f_wd[c])));
            check("wr_dqm", 32'(bus.mem_wr_dqm), 32'(exp_dqm(f_bt[c], f_addr[c])));
            check("wr_no_rd", 32'(bus.mem_rd_en), 0);
        end else begin
            check("rd_en", 32'(bus.mem_rd_en), 1);
            check("rd_addr", 32'(bus.mem_rd_addr), 32'(f_addr[c] >> 1));
            repeat (dly) begin
                tick;
                check("rd_wait", 32'(bus.rd_valid), 0);
            end
            bus.mem_rd_ready = 1'b1;
            bus.mem_rd_data  = rd;
            tick;
            bus.mem_rd_ready = 1'b0;
            check("rd_valid", 32'(bus.rd_valid), 1);
            check("rd_ch", 32'(bus.rd_ch), 32'(c));
            check("rd_err", 32'(bus.rd_err), 0);
            check("rd_data", 32'(bus.rd_data), 32'(exp_rdata(f_bt[c], f_addr[c], rd)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(bus.ch_gnt), 0);
        check({tag, "_rdv"}, 32'(bus.rd_valid), 0);
        check({tag, "_rdch"}, 32'(bus.rd_ch), 0);
        check({tag, "_rdd"}, 32'(bus.rd_data), 0);
        check({tag, "_rderr"}, 32'(bus.rd_err), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_wra"}, 32'(bus.mem_wr_addr), 0);
        check({tag, "_wrd"}, 32'(bus.mem_wr_data), 0);
        check({tag, "_wre"}, 32'(bus.mem_wr_en), 0);
        check({tag, "_dqm"}, 32'(bus.mem_wr_dqm), 0);
        check({tag, "_rda"}, 32'(bus.mem_rd_addr), 0);
        check({tag, "_rde"}, 32'(bus.mem_rd_en), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        logic [N-1:0] pend;

        bus.ch_req        = '0;
        bus.ch_we         = '0;
        bus.ch_byte       = '0;
        bus.ch_addr_bytes = '0;
        bus.ch_wdata      = '0;
        bus.mem_rd_data   = '0;
        bus.mem_rd_ready  = 1'b0;
        bus.mem_busy      = 1'b0;
        rst = 1'b0;
        tick;
        tick;
        check_all_zero("reset");
        rst = 1'b1;
        model_reset();
        tick;

        // word write on ch1
        set_ch(1, 1'b1, 1'b0, 25'h0000100, 16'hBEEF);
        grant(4'b0010, w);
        bus.ch_req[1] = 1'b0;
        check("ww_busy", 32'(bus.busy), 1);
        serve(1, 0, 16'h0);
        check("ww_addr_const", 32'(bus.mem_wr_addr), 32'h80);
        tick;
        check("ww_pulse", 32'(bus.mem_wr_en), 0);
        check("ww_idle", 32'(bus.busy), 0);

        // byte read, high lane, 5-cycle controller latency
        set_ch(2, 1'b0, 1'b1, 25'h0000101, 16'h0);
        grant(4'b0100, w);
        bus.ch_req[2] = 1'b0;
        serve(2, 5, 16'hA55A);
        check("br_const", 32'(bus.rd_data), 32'h00A5);

        // byte writes to both lanes
        set_ch(0, 1'b1, 1'b1, 25'h0000200, 16'h1234);
        grant(4'b0001, w);
        bus.ch_req[0] = 1'b0;
        serve(0, 0, 16'h0);
        set_ch(0, 1'b1, 1'b1, 25'h0000201, 16'h5678);
        grant(4'b0001, w);
        bus.ch_req[0] = 1'b0;
        serve(0, 0, 16'h0);

        // read timeout, then a late ready that must be ignored
        set_ch(3, 1'b0, 1'b0, 25'h00ABCDE, 16'h0);
        grant(4'b1000, w);
        bus.ch_req[3] = 1'b0;
        tick;
        check("to_rd_en", 32'(bus.mem_rd_en), 1);
        repeat (T - 1) tick;
        check("to_early", 32'(bus.rd_valid), 0);
        tick;
        check("to_valid", 32'(bus.rd_valid), 1);
        check("to_err", 32'(bus.rd_err), 1);
        check("to_data", 32'(bus.rd_data), 0);
        check("to_ch", 32'(bus.rd_ch), 3);
        bus.mem_rd_ready = 1'b1;
        bus.mem_rd_data  = 16'hFFFF;
        tick;
        bus.mem_rd_ready = 1'b0;
        check("late_ready", 32'(bus.rd_valid), 0);
        check("late_busy", 32'(bus.busy), 0);

        // ready on the expiry cycle: data wins
        set_ch(1, 1'b0, 1'b0, 25'h0001000, 16'h0);
        grant(4'b0010, w);
        bus.ch_req[1] = 1'b0;
        serve(1, T - 1, 16'hC3C3);

        // backpressure from the controller
        bus.mem_busy = 1'b1;
        set_ch(3, 1'b1, 1'b0, 25'h1FFFFFE, 16'h5A5A);
        bus.ch_req = 4'b1000;
        repeat (10) begin
            tick;
            check("bp_gnt", 32'(bus.ch_gnt), 0);
            check("bp_en", 32'(bus.mem_wr_en | bus.mem_rd_en), 0);
        end
        bus.mem_busy = 1'b0;
        grant(4'b1000, w);
        bus.ch_req[3] = 1'b0;
        serve(3, 0, 16'h0);

        // contention from a fresh reset: all channels read continuously
        bus.ch_req = '0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < N; c++)
            set_ch(c, 1'b0, 1'b0, AW'(32'h400 + c * 2), 16'h0);
        for (int i = 0; i < 5; i++) begin
            grant(4'hF, w);
            serve(w, 0, 16'($urandom));
        end
        bus.ch_req = '0;
        tick;

        // reset while waiting for read data
        set_ch(2, 1'b0, 1'b0, 25'h0003456, 16'h0);
        grant(4'b0100, w);
        bus.ch_req[2] = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b0;
        tick;
        check_all_zero("midrst");
        rst = 1'b1;
        model_reset();
        bus.mem_rd_ready = 1'b1;
        bus.mem_rd_data  = 16'h1111;
        tick;
        bus.mem_rd_ready = 1'b0;
        check("midrst_nov1", 32'(bus.rd_valid), 0);
        tick;
        check("midrst_nov2", 32'(bus.rd_valid), 0);
        set_ch(1, 1'b0, 1'b1, 25'h0000010, 16'h0);
        grant(4'b0010, w);
        bus.ch_req[1] = 1'b0;
        serve(1, 2, 16'h7E81);

        // randomized traffic with overlapping pending requests
        pend = '0;
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1'b1;
                    new_req(c);
                end
            end
            if (pend == '0) begin
                pend[it % N] = 1'b1;
                new_req(it % N);
            end
            grant(pend, w);
            pend[w] = 1'b0;
            bus.ch_req = pend;
            serve(w, $urandom_range(0, 6), 16'($urandom));
        end
        bus.ch_req = '0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_ram_arbiter.md
Name: layer_ram_arbiter

Overview:
- Parametrised N-channel front end to the layer-RAM SDRAM controller.
- Replaces the fixed two-source (controller/pipeline) mux.
- Arbitrates word/byte reads and writes from NUM_CH requestors and drives the controller host interface, one operation at a time.
- Returns tagged read data with byte-lane extraction, byte-write masking and a read-timeout error path.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8); channel 0 is the GPU controller by convention.
- ADDR_W, 25, byte-address width; memory word address is ADDR_W-1 bits.
- TIMEOUT_CYC, 64, max cycles waiting for mem_rd_ready before the read is errored (>=4).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-low reset
- ch_req  in  NUM_CH  request per channel, held until granted
- ch_we  in  NUM_CH  1 = write, 0 = read
- ch_byte  in  NUM_CH  1 = 8-bit access, 0 = 16-bit access
- ch_addr_bytes  in  NUM_CH*ADDR_W  packed byte addresses
- ch_wdata  in  NUM_CH*16  packed write data (byte writes use [7:0])
- ch_gnt  out  NUM_CH  one-hot, one-cycle accept pulse
- rd_valid  out  1  read response strobe, one cycle
- rd_ch  out  $clog2(NUM_CH)  channel the response belongs to
- rd_data  out  16  response data
- rd_err  out  1  response is a timeout error (rd_data = 0)
- busy  out  1  arbiter not in IDLE
- mem_wr_addr  out  ADDR_W-1  controller write word address
- mem_wr_data  out  16  controller write data
- mem_wr_en  out  1  controller write enable, one-cycle pulse
- mem_wr_dqm  out  2  byte mask, 1 = lane masked, [1] = high lane
- mem_rd_addr  out  ADDR_W-1  controller read word address
- mem_rd_en  out  1  controller read enable, one-cycle pulse
- mem_rd_data  in  16  controller read data
- mem_rd_ready  in  1  controller read data valid
- mem_busy  in  1  controller busy

Behaviour:
- Reset (rst low at a clk edge): all outputs 0, state IDLE, timeout counter 0, round-robin pointer 0.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any ch_req and !mem_busy: pick a winner, register its we/byte/addr/wdata and its index, pulse ch_gnt[winner], go to ISSUE.
  - mem_rd_ready is ignored in IDLE.
- ISSUE (exactly one cycle): drive mem_*_en for this cycle only, with addr = addr_bytes[ADDR_W-1:1].
  - Write → IDLE.
  - Read → WAIT_RD with counter = 0.
- Write lane rules:
  - Word write: mem_wr_data = wdata, dqm = 2'b00.
  - Byte write: mem_wr_data = {wdata[7:0], wdata[7:0]}; dqm = 2'b10 if addr[0] = 0, 2'b01 if addr[0] = 1.
  - addr[0] is ignored on word accesses.
- WAIT_RD:
  - Counter increments each cycle.
  - On mem_rd_ready: next cycle rd_valid = 1, rd_ch = latched index, rd_err = 0; go to IDLE.
  - rd_data for a byte read is {8'h00, mem_rd_data[15:8]} if addr[0] = 1, else {8'h00, mem_rd_data[7:0]}; for a word read it is mem_rd_data.
  - If the counter reaches TIMEOUT_CYC-1 without mem_rd_ready: rd_valid = 1, rd_err = 1, rd_data = 0; go to IDLE.
  - mem_rd_ready in the same cycle as expiry: data wins, rd_err = 0.
- Latency: read request to ch_gnt is 1 cycle; mem_rd_en follows gnt by 1 cycle; rd_valid follows mem_rd_ready by 1 cycle. Writes sustain at most one per 2 cycles.
- Handshake:
  - Requestor holds req and fields stable until it sees gnt.
  - It may present a new request the cycle after gnt.
  - Only one read is outstanding at a time.
- rst low mid-operation: return to IDLE immediately, drop any pending response, emit no rd_valid.

Optional Feature:
- LAYER_RAM_RR_EN defined: round-robin arbitration. The search starts at pointer+1 (mod NUM_CH); the pointer updates to the winner on each grant.
- Not defined: fixed priority, lowest index wins (channel 0 always preferred); no pointer register.

Decomposition:
- Package layer_ram_pkg holds:
  - state enum (IDLE/ISSUE/WAIT_RD)
  - DQM_NONE/DQM_LO/DQM_HI constants
  - a CH_W(NUM_CH) width function
- Sub-module layer_ram_pick: combinational request vector plus pointer → one-hot winner and index. It contains the LAYER_RAM_RR_EN selection.

Test Plan:
- Word write: ch1 we, addr 0x0000100, wdata 0xBEEF → gnt[1] for 1 cycle, then mem_wr_en with mem_wr_addr 0x000080, data 0xBEEF, dqm 00.
- Byte read: ch2 byte read at addr 0x0000101; controller returns 0xA55A after 5 cycles → rd_valid, rd_ch = 2, rd_data 0x00A5, rd_err 0.
- Contention: all 4 channels request reads continuously.
  - RR build: grants in order 1, 2, 3, 0, 1.
  - Fixed build: ch0 granted every time it requests.
- Timeout: read issued, mem_rd_ready never asserted → rd_valid with rd_err = 1, rd_data 0 exactly TIMEOUT_CYC cycles after mem_rd_en. A late mem_rd_ready is ignored.
- Backpressure: mem_busy held high for 10 cycles with ch3 requesting → no gnt or enables until the cycle after busy drops.
- Reset mid-read: rst low during WAIT_RD → all outputs 0 next cycle, no rd_valid afterwards, next request served normally.
